uart_phy_fifo: RTL and testbench

UART_PHY_FIFO -- requirements
Module: uart_phy_fifo

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_sync_fifo.sv | 67 ++++++
 rtl/uart_phy_fifo.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_uart_phy_fifo.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART PHY with RX/TX FIFOs.
// Holds the parity mode encodings, the FSM state type shared by the RX and TX
// engines, the smallest usable clocks-per-bit value and a parity helper.
package uart_pkg;

   // Parity mode encodings for the PARITY parameter
   localparam int unsigned ParityNone = 0;
   localparam int unsigned ParityEven = 1;
   localparam int unsigned ParityOdd  = 2;

   // Below this the half-bit start sample and the synchroniser latency collide
   localparam int unsigned MinDiv = 4;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop
   } uart_state_e;

   // Parity bit that makes the frame satisfy the selected mode
   function automatic logic parity_bit(input logic [7:0] data, input int unsigned mode);
      logic p;
      case (mode)
         ParityEven: p = ^data;
         ParityOdd:  p = ~(^data);
         default:    p = 1'b0;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Byte-wide synchronous FIFO, first-word-fall-through.
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   wr_en_i, wdata_i push request and data
//   rd_en_i          pop request
//   rdata_o          head byte (0 while empty)
//   empty_o          FIFO holds no data
//   cnt_o            occupancy, AW+1 bits (MSB set means full)
//   ovf_o            push request dropped this cycle (full, no pop)
module uart_sync_fifo #(
   parameter int unsigned AW = 3
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          wr_en_i,
   input  logic [7:0]    wdata_i,
   input  logic          rd_en_i,
   output logic [7:0]    rdata_o,
   output logic          empty_o,
   output logic [AW:0]   cnt_o,
   output logic          ovf_o
);

   localparam int unsigned Depth = 2 ** AW;
   localparam int unsigned CW    = AW + 1;

   logic [7:0]    mem_q [Depth];
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          full, rd_ok, wr_ok;

   assign empty_o = (cnt_q == '0);
   assign full    = (cnt_q == CW'(Depth));
   assign rd_ok   = rd_en_i && !empty_o;
   // A pop in the same cycle frees the slot, so a push on full still lands
   assign wr_ok   = wr_en_i && (!full || rd_ok);
   assign ovf_o   = wr_en_i && !wr_ok;
   assign cnt_o   = cnt_q;
   assign rdata_o = empty_o ? 8'h00 : mem_q[rptr_q];

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q + CW'(wr_ok) - CW'(rd_ok);
      if (wr_ok) wptr_d = wptr_q + AW'(1);
      if (rd_ok) rptr_d = rptr_q + AW'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   // Storage needs no reset: rdata_o is masked while empty
   always_ff @(posedge clk_i) begin
      if (wr_ok) mem_q[wptr_q] <= wdata_i;
   end

endmodule

// File: rtl/uart_phy_fifo.sv
// UART PHY with an RX FIFO and a TX FIFO.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   rx, tx                      serial in (asynchronous) / serial out (idle high)
//   rx_rden, rx_rdata           pop / head byte of the RX FIFO (fall-through)
//   rx_fifo_dvalid, _full       RX FIFO non-empty / full
//   rx_fifo_rcntrs              RX FIFO occupancy
//   rx_fifo_overrun/_underrun   sticky: received byte dropped / pop on empty
//   rx_frame_err, rx_parity_err sticky: stop bit low / parity mismatch
//   tx_wdata, tx_wten           byte to send / push strobe
//   tx_fifo_full                TX FIFO full
//   tx_fifo_overrun             sticky: push on full dropped
//   tx_fifo_underrun            tied 0
//   clear_err                   clears every sticky flag
module uart_phy_fifo #(
   parameter int unsigned DIV       = 434,
   parameter int unsigned FIFO_AW   = 3,
   parameter int unsigned PARITY    = 0,
   parameter int unsigned STOP_BITS = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rx,
   output logic               tx,
   input  logic               rx_rden,
   output logic [7:0]         rx_rdata,
   output logic               rx_fifo_dvalid,
   output logic               rx_fifo_full,
   output logic               rx_fifo_overrun,
   output logic               rx_fifo_underrun,
   output logic [FIFO_AW:0]   rx_fifo_rcntrs,
   output logic               rx_frame_err,
   output logic               rx_parity_err,
   input  logic [7:0]         tx_wdata,
   input  logic               tx_wten,
   output logic               tx_fifo_full,
   output logic               tx_fifo_overrun,
   output logic               tx_fifo_underrun,
   input  logic               clear_err
);

   import uart_pkg::*;

   localparam int unsigned BitDiv = (DIV < MinDiv) ? MinDiv : DIV;
   localparam int unsigned CntW   = $clog2(BitDiv);

   // ---------------- RX ----------------
   logic            rx_s1_q, rx_s2_q, rx_prev_q;
   uart_state_e     rx_state_q, rx_state_d;
   logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]      rx_bit_q, rx_bit_d;
   logic [7:0]      rx_shift_q, rx_shift_d;
   logic            rx_bad_q, rx_bad_d;   // parity failed in the current frame
   logic            rx_brk_q, rx_brk_d;   // stop bit was low, wait for line high
   logic            rx_push_q, rx_push_d;
   logic            rx_perr_set, rx_ferr_set;
   logic            rx_ovf, rx_empty;
   logic            rx_ovr_q, rx_udr_q, rx_ferr_q, rx_perr_q;

   always_comb begin
      rx_state_d  = rx_state_q;
      rx_cnt_d    = rx_cnt_q + CntW'(1);
      rx_bit_d    = rx_bit_q;
      rx_shift_d  = rx_shift_q;
      rx_bad_d    = rx_bad_q;
      rx_brk_d    = rx_brk_q;
      rx_push_d   = 1'b0;
      rx_perr_set = 1'b0;
      rx_ferr_set = 1'b0;
      unique case (rx_state_q)
         StIdle: begin
            rx_cnt_d = '0;
            if (rx_prev_q && !rx_s2_q) begin
               rx_state_d = StStart;
               rx_bad_d   = 1'b0;
               rx_brk_d   = 1'b0;
            end
         end
         StStart: begin
            if (rx_cnt_q == CntW'(BitDiv / 2 - 1)) begin
               rx_cnt_d   = '0;
               rx_bit_d   = '0;
               // Line back high at mid-start: treat as a glitch
               rx_state_d = rx_s2_q ? StIdle : StData;
            end
         end
         StData: begin
            if (rx_cnt_q == CntW'(BitDiv - 1)) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
               rx_bit_d   = rx_bit_q + 3'd1;
               if (rx_bit_q == 3'd7) rx_state_d = (PARITY != ParityNone) ? StParity : StStop;
            end
         end
         StParity: begin
            if (rx_cnt_q == CntW'(BitDiv - 1)) begin
               rx_cnt_d   = '0;
               rx_state_d = StStop;
               if (rx_s2_q != parity_bit(rx_shift_q, PARITY)) begin
                  rx_bad_d    = 1'b1;
                  rx_perr_set = 1'b1;
               end
            end
         end
         StStop: begin
            if (rx_brk_q) begin
               rx_cnt_d = '0;
               if (rx_s2_q) rx_state_d = StIdle;
            end else if (rx_cnt_q == CntW'(BitDiv - 1)) begin
               rx_cnt_d = '0;
               if (!rx_s2_q) begin
                  rx_ferr_set = 1'b1;
                  rx_brk_d    = 1'b1;
               end else begin
                  rx_push_d  = !rx_bad_q;
                  rx_state_d = StIdle;
               end
            end
         end
         default: rx_state_d = StIdle;
      endcase
   end

   uart_sync_fifo #(
      .AW (FIFO_AW)
   ) u_rx_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .wr_en_i (rx_push_q),
      .wdata_i (rx_shift_q),
      .rd_en_i (rx_rden),
      .rdata_o (rx_rdata),
      .empty_o (rx_empty),
      .cnt_o   (rx_fifo_rcntrs),
      .ovf_o   (rx_ovf)
   );

   assign rx_fifo_dvalid   = !rx_empty;
   assign rx_fifo_full     = rx_fifo_rcntrs[FIFO_AW];
   assign rx_fifo_overrun  = rx_ovr_q;
   assign rx_fifo_underrun = rx_udr_q;
   assign rx_frame_err     = rx_ferr_q;
   assign rx_parity_err    = rx_perr_q;

   // ---------------- TX ----------------
   uart_state_e     tx_state_q, tx_state_d;
   logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]      tx_bit_q, tx_bit_d;
   logic            tx_stop_q, tx_stop_d;
   logic [7:0]      tx_shift_q, tx_shift_d;
   logic            tx_par_q, tx_par_d;
   logic            tx_q, tx_d;
   logic            tx_pop, tx_last, tx_last_stop;
   logic            tx_empty, tx_ovf;
   logic [7:0]      tx_head;
   logic [FIFO_AW:0] tx_cnt;
   logic            tx_ovr_q;

   always_comb begin
      tx_state_d   = tx_state_q;
      tx_cnt_d     = tx_cnt_q + CntW'(1);
      tx_bit_d     = tx_bit_q;
      tx_stop_d    = tx_stop_q;
      tx_shift_d   = tx_shift_q;
      tx_par_d     = tx_par_q;
      tx_d         = tx_q;
      tx_pop       = 1'b0;
      tx_last      = (tx_cnt_q == CntW'(BitDiv - 1));
      tx_last_stop = (STOP_BITS < 2) || tx_stop_q;
      unique case (tx_state_q)
         StIdle: begin
            tx_d     = 1'b1;
            tx_cnt_d = '0;
            if (!tx_empty) begin
               tx_pop     = 1'b1;
               tx_shift_d = tx_head;
               tx_par_d   = parity_bit(tx_head, PARITY);
               tx_state_d = StStart;
               tx_d       = 1'b0;
            end
         end
         StStart: begin
            if (tx_last) begin
               tx_cnt_d   = '0;
               tx_bit_d   = '0;
               tx_state_d = StData;
               tx_d       = tx_shift_q[0];
            end
         end
         StData: begin
            if (tx_last) begin
               tx_cnt_d   = '0;
               tx_bit_d   = tx_bit_q + 3'd1;
               tx_shift_d = {1'b0, tx_shift_q[7:1]};
               tx_d       = tx_shift_q[1];
               if (tx_bit_q == 3'd7) begin
                  tx_stop_d = 1'b0;
                  if (PARITY != ParityNone) begin
                     tx_state_d = StParity;
                     tx_d       = tx_par_q;
                  end else begin
                     tx_state_d = StStop;
                     tx_d       = 1'b1;
                  end
               end
            end
         end
         StParity: begin
            if (tx_last) begin
               tx_cnt_d   = '0;
               tx_state_d = StStop;
               tx_d       = 1'b1;
            end
         end
         StStop: begin
            if (tx_last) begin
               tx_cnt_d = '0;
               if (!tx_last_stop) begin
                  tx_stop_d = 1'b1;
               end else if (!tx_empty) begin
                  // Next byte starts right after the stop bit, no idle gap
                  tx_pop     = 1'b1;
                  tx_shift_d = tx_head;
                  tx_par_d   = parity_bit(tx_head, PARITY);
                  tx_state_d = StStart;
                  tx_d       = 1'b0;
               end else begin
                  tx_state_d = StIdle;
               end
            end
         end
         default: tx_state_d = StIdle;
      endcase
   end

   uart_sync_fifo #(
      .AW (FIFO_AW)
   ) u_tx_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .wr_en_i (tx_wten),
      .wdata_i (tx_wdata),
      .rd_en_i (tx_pop),
      .rdata_o (tx_head),
      .empty_o (tx_empty),
      .cnt_o   (tx_cnt),
      .ovf_o   (tx_ovf)
   );

   assign tx               = tx_q;
   assign tx_fifo_full     = tx_cnt[FIFO_AW];
   assign tx_fifo_overrun  = tx_ovr_q;
   assign tx_fifo_underrun = 1'b0;

   // ---------------- State ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_s1_q    <= 1'b1;
         rx_s2_q    <= 1'b1;
         rx_prev_q  <= 1'b1;
         rx_state_q <= StIdle;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         rx_bad_q   <= 1'b0;
         rx_brk_q   <= 1'b0;
         rx_push_q  <= 1'b0;
         tx_state_q <= StIdle;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_stop_q  <= 1'b0;
         tx_shift_q <= '0;
         tx_par_q   <= 1'b0;
         tx_q       <= 1'b1;
         rx_ovr_q   <= 1'b0;
         rx_udr_q   <= 1'b0;
         rx_ferr_q  <= 1'b0;
         rx_perr_q  <= 1'b0;
         tx_ovr_q   <= 1'b0;
      end else begin
         rx_s1_q    <= rx;
         rx_s2_q    <= rx_s1_q;
         rx_prev_q  <= rx_s2_q;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         rx_bad_q   <= rx_bad_d;
         rx_brk_q   <= rx_brk_d;
         rx_push_q  <= rx_push_d;
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_stop_q  <= tx_stop_d;
         tx_shift_q <= tx_shift_d;
         tx_par_q   <= tx_par_d;
         tx_q       <= tx_d;
         // Set events take priority over clear_err
         rx_ovr_q   <= rx_ovf | (rx_ovr_q & ~clear_err);
         rx_udr_q   <= (rx_rden & rx_empty) | (rx_udr_q & ~clear_err);
         rx_ferr_q  <= rx_ferr_set | (rx_ferr_q & ~clear_err);
         rx_perr_q  <= rx_perr_set | (rx_perr_q & ~clear_err);
         tx_ovr_q   <= tx_ovf | (tx_ovr_q & ~clear_err);
      end
   end

endmodule

// File: tb/tb_uart_phy_fifo.sv
module tb_uart_phy_fifo;

   localparam int unsigned Div = 8;
   localparam int unsigned Aw  = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic clr = 1'b0;

   // Instance 0: no parity, loopback-capable
   logic          loop = 1'b0;
   logic          rx0_drv = 1'b1;
   logic          rx0, tx0;
   logic          rden0 = 1'b0, wten0 = 1'b0;
   logic [7:0]    wdata0 = 8'h00, rdata0;
   logic          dv0, full0, rovr0, rudr0, ferr0, perr0, tfull0, tovr0, tudr0;
   logic [Aw:0]   rcnt0;

   // Instance 1: even parity, RX only
   logic          rx1 = 1'b1, tx1;
   logic          rden1 = 1'b0, wten1 = 1'b0;
   logic [7:0]    wdata1 = 8'h00, rdata1;
   logic          dv1, full1, rovr1, rudr1, ferr1, perr1, tfull1, tovr1, tudr1;
   logic [Aw:0]   rcnt1;

   int total = 0;
   int bad   = 0;

   logic [7:0] rxq0[$];
   logic [7:0] rxq1[$];
   logic [7:0] txq[$];

   assign rx0 = loop ? tx0 : rx0_drv;

   always #5 clk = ~clk;

   uart_phy_fifo #(
      .DIV (Div), .FIFO_AW (Aw), .PARITY (0), .STOP_BITS (1)
   ) dut0 (
      .clk (clk), .rst (rst), .rx (rx0), .tx (tx0),
      .rx_rden (rden0), .rx_rdata (rdata0), .rx_fifo_dvalid (dv0),
      .rx_fifo_full (full0), .rx_fifo_overrun (rovr0), .rx_fifo_underrun (rudr0),
      .rx_fifo_rcntrs (rcnt0), .rx_frame_err (ferr0), .rx_parity_err (perr0),
      .tx_wdata (wdata0), .tx_wten (wten0), .tx_fifo_full (tfull0),
      .tx_fifo_overrun (tovr0), .tx_fifo_underrun (tudr0), .clear_err (clr)
   );

   uart_phy_fifo #(
      .DIV (Div), .FIFO_AW (Aw), .PARITY (1), .STOP_BITS (1)
   ) dut1 (
      .clk (clk), .rst (rst), .rx (rx1), .tx (tx1),
      .rx_rden (rden1), .rx_rdata (rdata1), .rx_fifo_dvalid (dv1),
      .rx_fifo_full (full1), .rx_fifo_overrun (rovr1), .rx_fifo_underrun (rudr1),
      .rx_fifo_rcntrs (rcnt1), .rx_frame_err (ferr1), .rx_parity_err (perr1),
      .tx_wdata (wdata1), .tx_wten (wten1), .tx_fifo_full (tfull1),
      .tx_fifo_overrun (tovr1), .tx_fifo_underrun (tudr1), .clear_err (clr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic rx_bit(input int sel, input logic v);
      if (sel == 0) rx0_drv = v;
      else rx1 = v;
      repeat (Div) @(negedge clk);
   endtask

   // Start, 8 data LSB-first, optional parity (flip to corrupt), stop, 2 idle bits
   task automatic send_frame(input int sel, input logic [7:0] b, input int par_mode,
                             input logic par_flip, input logic stop_v);
      rx_bit(sel, 1'b0);
      for (int i = 0; i < 8; i++) rx_bit(sel, b[i]);
      if (par_mode != 0) rx_bit(sel, (((par_mode == 2) ? ~(^b) : ^b)) ^ par_flip);
      rx_bit(sel, stop_v);
      rx_bit(sel, 1'b1);
      rx_bit(sel, 1'b1);
   endtask

   task automatic pop0(input string tag);
      logic [7:0] e;
      e = 8'h00;
      chk({tag, "_dvalid"}, dv0, 1);
      if (rxq0.size() > 0) e = rxq0.pop_front();
      chk(tag, rdata0, e);
      rden0 = 1'b1;
      @(negedge clk);
      rden0 = 1'b0;
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] fr;
      logic [7:0] e;
      logic [7:0] b;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_tx0", tx0, 1);
      chk("rst_tx1", tx1, 1);
      chk("rst_rdata0", rdata0, 0);
      chk("rst_rcnt0", rcnt0, 0);
      chk("rst_flags0", {dv0, full0, rovr0, rudr0, ferr0, perr0, tfull0, tovr0, tudr0}, 0);
      chk("rst_flags1", {rdata1, rcnt1, dv1, full1, rovr1, rudr1, ferr1, perr1,
                         tfull1, tovr1, tudr1}, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Loopback of 0xA5 with start-bit latency
      loop   = 1'b1;
      wdata0 = 8'hA5;
      wten0  = 1'b1;
      rxq0.push_back(8'hA5);
      @(negedge clk);
      wten0 = 1'b0;
      chk("tx_before_start", tx0, 1);
      @(negedge clk);
      chk("tx_start_2cyc", tx0, 0);
      for (int i = 0; i < 200 && !dv0; i++) @(negedge clk);
      pop0("loop_a5");
      chk("loop_flags", {rovr0, rudr0, ferr0, perr0, tovr0}, 0);
      repeat (2 * Div) @(negedge clk);
      loop = 1'b0;
      repeat (2 * Div) @(negedge clk);

      // Frame error then a good byte
      send_frame(0, 8'h55, 0, 1'b0, 1'b0);
      chk("ferr_set", ferr0, 1);
      chk("ferr_no_push", dv0, 0);
      send_frame(0, 8'h3C, 0, 1'b0, 1'b1);
      rxq0.push_back(8'h3C);
      pop0("after_ferr_3c");
      pulse_clr();
      chk("ferr_clear", ferr0, 0);

      // Parity error on the even-parity instance
      send_frame(1, 8'h0F, 1, 1'b1, 1'b1);
      chk("perr_set", perr1, 1);
      chk("perr_no_push", rcnt1, 0);
      pulse_clr();
      chk("perr_clear", perr1, 0);
      send_frame(1, 8'h07, 1, 1'b0, 1'b1);
      rxq1.push_back(8'h07);
      chk("par_good_dv", dv1, 1);
      e = rxq1.pop_front();
      chk("par_good_data", rdata1, e);
      chk("par_good_noerr", perr1, 0);

      // Start glitch of 2 cycles
      rx0_drv = 1'b0;
      repeat (2) @(negedge clk);
      rx0_drv = 1'b1;
      repeat (3 * Div) @(negedge clk);
      chk("glitch_no_push", {dv0, rcnt0}, 0);
      chk("glitch_no_ferr", ferr0, 0);

      // Five bytes without reading: depth 4 stored, fifth dropped
      for (int i = 1; i <= 5; i++) begin
         b = 8'(i);
         send_frame(0, b, 0, 1'b0, 1'b1);
         if (rxq0.size() < (1 << Aw)) rxq0.push_back(b);
      end
      chk("ovr_rcnt", rcnt0, 4);
      chk("ovr_full", full0, 1);
      chk("ovr_flag", rovr0, 1);
      for (int i = 0; i < 4; i++) pop0("ovr_pop");
      chk("ovr_drained", rcnt0, 0);
      rden0 = 1'b1;
      @(negedge clk);
      rden0 = 1'b0;
      chk("udr_flag", rudr0, 1);
      chk("udr_rcnt", rcnt0, 0);
      pulse_clr();
      chk("clr_all", {rovr0, rudr0}, 0);

      // Six back-to-back writes: four queued plus one taken by TX
      for (int i = 0; i < 6; i++) begin
         b = 8'(8'hC1 + i * 13);
         wdata0 = b;
         wten0  = 1'b1;
         if (i < (1 << Aw) + 1) txq.push_back(b);
         @(negedge clk);
      end
      wten0 = 1'b0;
      chk("tx_ovr", tovr0, 1);
      chk("tx_full", tfull0, 1);
      // Now at the centre of the first start bit; frames must be exactly 80 cycles apart
      for (int f = 0; f < 5; f++) begin
         for (int i = 0; i < 10; i++) begin
            fr[i] = tx0;
            repeat (Div) @(negedge clk);
         end
         e = (txq.size() > 0) ? txq.pop_front() : 8'h00;
         chk("tx_frame", fr, {1'b1, e, 1'b0});
      end
      chk("tx_idle_after", tx0, 1);
      pulse_clr();

      // Reset in the middle of a TX byte and an RX frame
      wdata0 = 8'h00;
      wten0  = 1'b1;
      @(negedge clk);
      wdata0 = 8'h12;
      @(negedge clk);
      wten0   = 1'b0;
      rx0_drv = 1'b0;
      repeat (20) @(negedge clk);
      chk("tx_mid_frame", tx0, 0);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_tx", tx0, 1);
      chk("rst_mid_tfull", tfull0, 0);
      rst     = 1'b0;
      rx0_drv = 1'b1;
      repeat (4 * Div) @(negedge clk);
      chk("rst_tx_stays_idle", tx0, 1);
      chk("rst_rx_discard", {dv0, rcnt0, ferr0}, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
